// File: rtl/ad_ip_jesd204_tpl_dac_chan_gen_pkg.sv
// Shared TPL DAC channel definitions: source select codes and helpers,
// common to the channel generator, register map and sibling TPL blocks.
package ad_ip_jesd204_tpl_dac_chan_gen_pkg;

    typedef enum logic [3:0] {
        SEL_DDS      = 4'd0,
        SEL_PAT      = 4'd1,
        SEL_DMA      = 4'd2,
        SEL_ZERO     = 4'd3,
        SEL_PN7_INV  = 4'd4,
        SEL_PN15_INV = 4'd5,
        SEL_PN7      = 4'd6,
        SEL_PN15     = 4'd7,
        SEL_HOLD     = 4'd8,
        SEL_RAMP     = 4'd9
    } dac_sel_e;

    localparam logic [15:0] UF_CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == UF_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_pat_buf.sv
// Multi-beat pattern buffer: PAT_DEPTH x CR register array plus a looping
// beat pointer; presents the current beat combinationally.
module ad_ip_jesd204_tpl_dac_pat_buf #(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int CR              = 16,
    parameter int PAT_DEPTH       = 16,
    parameter int PAT_AW          = $clog2(PAT_DEPTH),
    parameter int PAT_BW          = (PAT_DEPTH / DATA_PATH_WIDTH > 1) ?
                                    $clog2(PAT_DEPTH / DATA_PATH_WIDTH) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_wr,
    input  logic [PAT_AW-1:0]             i_waddr,
    input  logic [CR-1:0]                 i_wdata,
    input  logic [PAT_BW-1:0]             i_last_beat,
    input  logic                          i_sync,
    output logic [DATA_PATH_WIDTH*CR-1:0] o_beat
);

    logic [CR-1:0]     r_mem [PAT_DEPTH];
    logic [PAT_BW-1:0] r_ptr;

    // NOTE: this is a small register file whose contents are architecturally
    // defined after reset, so every entry is cleared; a true RAM would not be.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < PAT_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_wr) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Using >= rather than == lets a lowered last_beat pull the pointer back at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (i_sync || (r_ptr >= i_last_beat)) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= r_ptr + PAT_BW'(1);
        end
    end

    for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_lane
        logic [PAT_AW-1:0] w_raddr;
        assign w_raddr = PAT_AW'(int'(r_ptr) * DATA_PATH_WIDTH + i);
        assign o_beat[CR*i +: CR] = r_mem[w_raddr];
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_chan_gen.sv
// Per-channel DAC source selector with pattern buffer, ramp generator,
// hold mode and DMA underflow tracking; one registered output beat per clock.
module ad_ip_jesd204_tpl_dac_chan_gen
    import ad_ip_jesd204_tpl_dac_chan_gen_pkg::*;
#(
    parameter int DATA_PATH_WIDTH      = 4,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int PAT_DEPTH            = 16,
    parameter int PAT_AW               = $clog2(PAT_DEPTH),
    parameter int PAT_BW               = (PAT_DEPTH / DATA_PATH_WIDTH > 1) ?
                                         $clog2(PAT_DEPTH / DATA_PATH_WIDTH) : 1
) (
    input  logic                                            clk,
    input  logic                                            resetn,
    input  logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0]      dma_data,
    input  logic                                            dma_valid,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] dds_data,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] pn7_data,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] pn15_data,
    input  logic                                            dac_data_sync,
    input  logic [3:0]                                      dac_data_sel,
    input  logic                                            dac_pat_wr,
    input  logic [PAT_AW-1:0]                               dac_pat_waddr,
    input  logic [15:0]                                     dac_pat_wdata,
    input  logic [PAT_BW-1:0]                               dac_pat_last_beat,
    input  logic [15:0]                                     dac_ramp_init,
    input  logic [15:0]                                     dac_ramp_step,
    input  logic                                            dac_underflow_clr,
    output logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] dac_data,
    output logic                                            dac_enable,
    output logic                                            dac_underflow,
    output logic [15:0]                                     dac_underflow_cnt
);

    localparam int CR = CONVERTER_RESOLUTION;
    localparam int DW = DATA_PATH_WIDTH * CR;

    logic [DW-1:0] r_dac_data;
    logic [DW-1:0] w_dac_data_nxt;
    logic [DW-1:0] w_dma_beat;
    logic [DW-1:0] w_pat_beat;
    logic [DW-1:0] w_ramp_beat;
    logic [15:0]   r_ramp_base;
    logic [15:0]   w_ramp_base_nxt;
    logic          r_dac_enable;
    logic          r_underflow;
    logic [15:0]   r_underflow_cnt;
    logic          w_underflow;

    ad_ip_jesd204_tpl_dac_pat_buf #(
        .DATA_PATH_WIDTH (DATA_PATH_WIDTH),
        .CR              (CR),
        .PAT_DEPTH       (PAT_DEPTH),
        .PAT_AW          (PAT_AW),
        .PAT_BW          (PAT_BW)
    ) u_pat_buf (
        .clk         (clk),
        .resetn      (resetn),
        .i_wr        (dac_pat_wr),
        .i_waddr     (dac_pat_waddr),
        .i_wdata     (dac_pat_wdata[CR-1:0]),
        .i_last_beat (dac_pat_last_beat),
        .i_sync      (dac_data_sync),
        .o_beat      (w_pat_beat)
    );

    for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_lane
        logic [15:0] w_ramp_val;
        assign w_dma_beat[CR*i +: CR] = dma_valid ? dma_data[BITS_PER_SAMPLE*i +: CR] : '0;
        assign w_ramp_val             = r_ramp_base + 16'(i) * dac_ramp_step;
        assign w_ramp_beat[CR*i +: CR] = w_ramp_val[CR-1:0];
    end

    // The ramp runs free whatever the select; sync only reloads the base.
    assign w_ramp_base_nxt = dac_data_sync ? dac_ramp_init
                                           : r_ramp_base + 16'(DATA_PATH_WIDTH) * dac_ramp_step;
    assign w_underflow     = (dac_data_sel == SEL_DMA) && !dma_valid;

    // NOTE: combinational logic uses blocking assignments and starts from a
    // default so no path can leave the output unassigned and infer a latch.
    always_comb begin
        w_dac_data_nxt = '0;
        case (dac_data_sel)
            SEL_DDS:      w_dac_data_nxt = dds_data;
            SEL_PAT:      w_dac_data_nxt = w_pat_beat;
            SEL_DMA:      w_dac_data_nxt = w_dma_beat;
            SEL_PN7_INV:  w_dac_data_nxt = ~pn7_data;
            SEL_PN15_INV: w_dac_data_nxt = ~pn15_data;
            SEL_PN7:      w_dac_data_nxt = pn7_data;
            SEL_PN15:     w_dac_data_nxt = pn15_data;
            SEL_HOLD:     w_dac_data_nxt = r_dac_data;
            SEL_RAMP:     w_dac_data_nxt = w_ramp_beat;
            default:      w_dac_data_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dac_data      <= '0;
            r_dac_enable    <= 1'b0;
            r_ramp_base     <= '0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            r_dac_data   <= w_dac_data_nxt;
            r_dac_enable <= (dac_data_sel == SEL_DMA);
            r_ramp_base  <= w_ramp_base_nxt;
            // A fresh underflow outranks a coincident clear: it restarts the count at one.
            if (w_underflow) begin
                r_underflow     <= 1'b1;
                r_underflow_cnt <= dac_underflow_clr ? 16'd1 : sat_inc16(r_underflow_cnt);
            end else if (dac_underflow_clr) begin
                r_underflow     <= 1'b0;
                r_underflow_cnt <= '0;
            end
        end
    end

    assign dac_data          = r_dac_data;
    assign dac_enable        = r_dac_enable;
    assign dac_underflow     = r_underflow;
    assign dac_underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_chan_gen.sv
// Directed bench for the DAC channel generator at default parameters
// (4 lanes x 16 bits, 16-entry pattern buffer).
module tb_ad_ip_jesd204_tpl_dac_chan_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] dma_data;
    logic        dma_valid;
    logic [63:0] dds_data;
    logic [63:0] pn7_data;
    logic [63:0] pn15_data;
    logic        dac_data_sync;
    logic [3:0]  dac_data_sel;
    logic        dac_pat_wr;
    logic [3:0]  dac_pat_waddr;
    logic [15:0] dac_pat_wdata;
    logic [1:0]  dac_pat_last_beat;
    logic [15:0] dac_ramp_init;
    logic [15:0] dac_ramp_step;
    logic        dac_underflow_clr;
    logic [63:0] dac_data;
    logic        dac_enable;
    logic        dac_underflow;
    logic [15:0] dac_underflow_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [63:0] B0 = 64'h0003_0002_0001_0000;
    localparam logic [63:0] B1 = 64'h0007_0006_0005_0004;
    localparam logic [63:0] B2 = 64'h000B_000A_0009_0008;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_dac_chan_gen dut (
        .clk               (clk),
        .resetn            (resetn),
        .dma_data          (dma_data),
        .dma_valid         (dma_valid),
        .dds_data          (dds_data),
        .pn7_data          (pn7_data),
        .pn15_data         (pn15_data),
        .dac_data_sync     (dac_data_sync),
        .dac_data_sel      (dac_data_sel),
        .dac_pat_wr        (dac_pat_wr),
        .dac_pat_waddr     (dac_pat_waddr),
        .dac_pat_wdata     (dac_pat_wdata),
        .dac_pat_last_beat (dac_pat_last_beat),
        .dac_ramp_init     (dac_ramp_init),
        .dac_ramp_step     (dac_ramp_step),
        .dac_underflow_clr (dac_underflow_clr),
        .dac_data          (dac_data),
        .dac_enable        (dac_enable),
        .dac_underflow     (dac_underflow),
        .dac_underflow_cnt (dac_underflow_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn            = 1'b0;
        dma_data          = '0;
        dma_valid         = 1'b0;
        dds_data          = '0;
        pn7_data          = '0;
        pn15_data         = '0;
        dac_data_sync     = 1'b0;
        dac_data_sel      = 4'd3;
        dac_pat_wr        = 1'b0;
        dac_pat_waddr     = '0;
        dac_pat_wdata     = '0;
        dac_pat_last_beat = '0;
        dac_ramp_init     = '0;
        dac_ramp_step     = '0;
        dac_underflow_clr = 1'b0;

        #2;
        check("rst_data",   dac_data,          64'h0);
        check("rst_enable", dac_enable,        64'h0);
        check("rst_uf",     dac_underflow,     64'h0);
        check("rst_cnt",    dac_underflow_cnt, 64'h0);
        @(posedge clk);
        #2;
        resetn = 1'b1;

        // Load samples 0..15 into the pattern buffer.
        dac_pat_wr = 1'b1;
        for (int k = 0; k < 16; k++) begin
            dac_pat_waddr = 4'(k);
            dac_pat_wdata = 16'(k);
            tick();
        end
        dac_pat_wr = 1'b0;

        // Three-beat pattern loop.
        dac_pat_last_beat = 2'd2;
        dac_data_sel      = 4'd1;
        dac_data_sync     = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        tick(); check("pat_b0",   dac_data, B0);
        tick(); check("pat_b1",   dac_data, B1);
        tick(); check("pat_b2",   dac_data, B2);
        tick(); check("pat_wrap", dac_data, B0);
        tick(); check("pat_b1_2", dac_data, B1);

        // Lower last_beat below the current pointer (2).
        dac_pat_last_beat = 2'd1;
        tick(); check("lb_low_old",  dac_data, B2);
        tick(); check("lb_low_wrap", dac_data, B0);
        tick(); check("lb_low_b1",   dac_data, B1);
        tick(); check("lb_low_loop", dac_data, B0);

        // Write address 0 while the pointer reads beat 0.
        dac_pat_last_beat = 2'd2;
        dac_data_sync     = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        dac_pat_wr    = 1'b1;
        dac_pat_waddr = 4'd0;
        dac_pat_wdata = 16'h00AA;
        tick(); check("hazard_old", dac_data, B0);
        dac_pat_wr = 1'b0;
        tick();
        tick();
        tick(); check("hazard_new", dac_data, 64'h0003_0002_0001_00AA);

        // Ramp, with sel change coincident with sync.
        dac_data_sel  = 4'd9;
        dac_ramp_init = 16'h0010;
        dac_ramp_step = 16'h0001;
        dac_data_sync = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        tick(); check("ramp_first", dac_data, 64'h0013_0012_0011_0010);
        tick(); check("ramp_next",  dac_data, 64'h0017_0016_0015_0014);
        dac_ramp_init = 16'h0000;
        dac_ramp_step = 16'hFFFF;
        dac_data_sync = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        tick(); check("ramp_neg_first", dac_data, 64'hFFFD_FFFE_FFFF_0000);
        tick(); check("ramp_neg_next",  dac_data, 64'hFFF9_FFFA_FFFB_FFFC);

        // DMA valid, then underflow.
        dac_data_sel = 4'd2;
        dma_valid    = 1'b1;
        dma_data     = 64'h1111_2222_3333_4444;
        tick();
        check("dma_data",   dac_data,      64'h1111_2222_3333_4444);
        check("dma_enable", dac_enable,    64'h1);
        check("dma_no_uf",  dac_underflow, 64'h0);
        dma_valid = 1'b0;
        tick(); check("uf_cnt1", dac_underflow_cnt, 64'h1);
        tick();
        tick();
        check("uf_data",   dac_data,          64'h0);
        check("uf_cnt3",   dac_underflow_cnt, 64'h3);
        check("uf_flag",   dac_underflow,     64'h1);
        check("uf_enable", dac_enable,        64'h1);
        dac_underflow_clr = 1'b1;
        tick();
        check("uf_clr_coinc_cnt",  dac_underflow_cnt, 64'h1);
        check("uf_clr_coinc_flag", dac_underflow,     64'h1);
        dac_data_sel = 4'd3;
        tick();
        check("uf_clr_cnt",    dac_underflow_cnt, 64'h0);
        check("uf_clr_flag",   dac_underflow,     64'h0);
        check("uf_clr_enable", dac_enable,        64'h0);
        dac_underflow_clr = 1'b0;

        // Saturation of the underflow counter.
        dac_data_sel = 4'd2;
        for (int k = 0; k < 65534; k++) tick();
        check("uf_cnt_fffe", dac_underflow_cnt, 64'hFFFE);
        tick();
        check("uf_cnt_ffff", dac_underflow_cnt, 64'hFFFF);
        for (int k = 0; k < 5; k++) tick();
        check("uf_cnt_sat", dac_underflow_cnt, 64'hFFFF);

        // Remaining sources.
        dma_valid = 1'b1;
        dds_data  = 64'h0123_4567_89AB_CDEF;
        pn7_data  = 64'hF0F0_0F0F_AAAA_5555;
        pn15_data = 64'h1234_0000_FFFF_8001;
        dac_data_sel = 4'd0;  tick(); check("sel_dds",     dac_data, 64'h0123_4567_89AB_CDEF);
        dac_data_sel = 4'd4;  tick(); check("sel_pn7_inv", dac_data, 64'h0F0F_F0F0_5555_AAAA);
        dac_data_sel = 4'd6;  tick(); check("sel_pn7",     dac_data, 64'hF0F0_0F0F_AAAA_5555);
        dac_data_sel = 4'd5;  tick(); check("sel_pn15_inv", dac_data, 64'hEDCB_FFFF_0000_7FFE);
        dac_data_sel = 4'd12; tick(); check("sel_zero_12", dac_data, 64'h0);
        check("uf_sticky_flag", dac_underflow,     64'h1);
        check("uf_sticky_cnt",  dac_underflow_cnt, 64'hFFFF);

        // Hold freezes the last pn15 beat.
        dac_data_sel = 4'd7; tick(); check("sel_pn15", dac_data, 64'h1234_0000_FFFF_8001);
        dac_data_sel = 4'd8;
        pn15_data    = 64'h5555_6666_7777_8888;
        tick(); check("hold1", dac_data, 64'h1234_0000_FFFF_8001);
        pn15_data = 64'h9999_AAAA_BBBB_CCCC;
        tick(); check("hold2", dac_data, 64'h1234_0000_FFFF_8001);
        check("hold_enable", dac_enable, 64'h0);

        // Mid-pattern reset with the pointer at beat 1.
        dac_data_sel      = 4'd1;
        dac_pat_last_beat = 2'd2;
        dac_data_sync     = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        tick(); check("pre_rst_beat", dac_data, 64'h0003_0002_0001_00AA);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_async_data", dac_data,          64'h0);
        check("rst_async_en",   dac_enable,        64'h0);
        check("rst_async_uf",   dac_underflow,     64'h0);
        check("rst_async_cnt",  dac_underflow_cnt, 64'h0);
        @(posedge clk);
        #2;
        dac_ramp_step = 16'h0001;
        dac_ramp_init = 16'h0077;
        dac_pat_wr    = 1'b1;
        dac_pat_waddr = 4'd0;
        dac_pat_wdata = 16'h0055;
        resetn        = 1'b1;
        tick(); check("post_rst_b0_old", dac_data, 64'h0);
        dac_pat_wr = 1'b0;
        tick(); check("post_rst_mem_clr", dac_data, 64'h0);
        tick(); check("post_rst_b2",      dac_data, 64'h0);
        tick(); check("post_rst_ptr",     dac_data, 64'h0000_0000_0000_0055);
        dac_data_sel = 4'd9;
        tick(); check("post_rst_ramp",    dac_data, 64'h0013_0012_0011_0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
